// File: rtl/t_ff_counter_pkg.sv
// Shared constants and parameter legality check for the T-flip-flop counter.
package t_ff_counter_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_COUNT  = 1'b1;
    localparam logic DIR_DOWN    = 1'b0;
    localparam logic DIR_UP      = 1'b1;

    function automatic bit params_legal(input int width, input int modulus);
        if (width < 1 || width > 16) return 1'b0;
        return (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/t_ff_counter_cell.sv
// Single toggle flip-flop with synchronous active-high reset.
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/t_ff_counter.sv
// WIDTH-bit register of T flip-flops acting as a bitwise toggle bank or a
// modulo-MODULUS up/down counter with load, cascade carry and sticky wrap flag.
module t_ff_counter
    import t_ff_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co,
    output logic             wrap
);

    if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
        $error("t_ff_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] tv;
    logic             wrap_evt;
    logic             wrap_d;
    logic             wrap_q;
    logic             at_top;
    logic             at_bottom;

    // Out-of-range values (q > MAX_Q) are treated as "at top" so up-count wraps.
    assign at_top    = (q >= MAX_Q);
    assign at_bottom = (q == '0);

    always_comb begin
        q_d      = q;
        wrap_evt = 1'b0;
        if (load) begin
            q_d = d;
        end else if (en) begin
            if (mode == MODE_COUNT) begin
                if (up_dn == DIR_UP) begin
                    if (at_top) begin
                        q_d      = '0;
                        wrap_evt = 1'b1;
                    end else begin
                        q_d = q + ONE;
                    end
                end else begin
                    if (at_bottom) begin
                        q_d      = MAX_Q;
                        wrap_evt = 1'b1;
                    end else begin
                        q_d = q - ONE;
                    end
                end
            end else begin
                q_d = q ^ t;
            end
        end
    end

    // The register only ever sees the toggle vector, never the adder result.
    assign tv = q ^ q_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (tv[i]),
            .q   (q[i])
        );
    end

    always_comb begin
        wrap_d = wrap_q;
        if (load) begin
            wrap_d = 1'b0;
        end else if (wrap_evt) begin
            wrap_d = 1'b1;
        end else if (clr_wrap) begin
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign tc   = (mode == MODE_COUNT) && ((up_dn == DIR_UP) ? at_top : at_bottom);
    assign co   = tc & en & ~load;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_t_ff_counter.sv
// Randomized and directed bench for t_ff_counter against an arithmetic reference model.
module tb_t_ff_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         rst, en, mode, up_dn, load, clr_wrap;
    logic [W-1:0] t, d;
    logic [W-1:0] q0, q1;
    logic         tc0, co0, wrap0, tc1, co1, wrap1;

    int n_chk  = 0;
    int n_pass = 0;
    int m_q    = 0;
    int m_wrap = 0;

    always #5 clk = ~clk;

    t_ff_counter #(.WIDTH(W), .MODULUS(MOD)) u_lo (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .up_dn(up_dn), .t(t),
        .load(load), .d(d), .clr_wrap(clr_wrap),
        .q(q0), .tc(tc0), .co(co0), .wrap(wrap0)
    );

    t_ff_counter #(.WIDTH(W), .MODULUS(MOD)) u_hi (
        .clk(clk), .rst(rst), .en(co0), .mode(1'b1), .up_dn(1'b1), .t(4'b0000),
        .load(1'b0), .d(4'b0000), .clr_wrap(1'b0),
        .q(q1), .tc(tc1), .co(co1), .wrap(wrap1)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int model_tc();
        if (!mode) return 0;
        if (up_dn) return (m_q >= MOD - 1) ? 1 : 0;
        return (m_q == 0) ? 1 : 0;
    endfunction

    // Apply one edge of stimulus, check combinational outputs before the edge
    // and registered state after it against the model.
    task automatic cycle(input bit r, input bit l, input bit e, input bit m,
                         input bit u, input logic [W-1:0] tt,
                         input logic [W-1:0] dd, input bit c);
        int exp_tc;
        bit wrapped;
        rst = r; load = l; en = e; mode = m; up_dn = u; t = tt; d = dd; clr_wrap = c;
        #1;
        exp_tc = model_tc();
        check("tc", int'(tc0), exp_tc);
        check("co", int'(co0), exp_tc & int'(e) & int'(!l));
        @(posedge clk);
        wrapped = 1'b0;
        if (r) begin
            m_q = 0; m_wrap = 0;
        end else if (l) begin
            m_q = int'(dd); m_wrap = 0;
        end else begin
            if (e && m) begin
                if (u) begin
                    if (m_q >= MOD - 1) begin m_q = 0; wrapped = 1'b1; end
                    else m_q = m_q + 1;
                end else begin
                    if (m_q == 0) begin m_q = MOD - 1; wrapped = 1'b1; end
                    else m_q = m_q - 1;
                end
            end else if (e) begin
                m_q = m_q ^ int'(tt);
            end
            if (wrapped) m_wrap = 1;
            else if (c) m_wrap = 0;
        end
        #1;
        check("q", int'(q0), m_q);
        check("wrap", int'(wrap0), m_wrap);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b1; up_dn = 1'b0; load = 1'b1;
        clr_wrap = 1'b0; t = 4'b1111; d = 4'b1011;

        // Reset with garbage on every input, then count up from zero.
        cycle(1, 1, 1, 0, 1, 4'b0110, 4'b1101, 0);
        cycle(1, 0, 1, 1, 0, 4'b1111, 4'b0111, 1);
        check("rst_q", int'(q0), 0);
        check("rst_wrap", int'(wrap0), 0);
        cycle(0, 0, 1, 1, 1, 4'b0000, 4'b0000, 0);
        check("cnt_q1", int'(q0), 1);
        cycle(0, 0, 1, 1, 1, 4'b0000, 4'b0000, 0);
        check("cnt_q2", int'(q0), 2);

        // Up wrap.
        cycle(0, 1, 0, 1, 1, 4'b0000, 4'd8, 0);
        cycle(0, 0, 1, 1, 1, 4'b0000, 4'd0, 0);
        check("up_q9", int'(q0), 9);
        check("up_tc9", int'(tc0), 1);
        cycle(0, 0, 1, 1, 1, 4'b0000, 4'd0, 0);
        check("up_wrap_q", int'(q0), 0);
        check("up_wrap_flag", int'(wrap0), 1);
        cycle(0, 0, 1, 1, 1, 4'b0000, 4'd0, 0);
        check("up_q1", int'(q0), 1);
        cycle(0, 0, 0, 1, 1, 4'b0000, 4'd0, 1);
        check("clr_wrap", int'(wrap0), 0);

        // Down wrap with clr_wrap on the wrap edge.
        cycle(0, 1, 0, 1, 0, 4'b0000, 4'd1, 0);
        cycle(0, 0, 1, 1, 0, 4'b0000, 4'd0, 0);
        check("dn_tc0", int'(tc0), 1);
        cycle(0, 0, 1, 1, 0, 4'b0000, 4'd0, 1);
        check("dn_wrap_q", int'(q0), 9);
        check("dn_set_wins", int'(wrap0), 1);
        cycle(0, 0, 1, 1, 0, 4'b0000, 4'd0, 0);
        check("dn_q8", int'(q0), 8);

        // Toggle mode.
        cycle(0, 1, 0, 0, 1, 4'b0000, 4'd0, 0);
        cycle(0, 0, 1, 0, 1, 4'b1010, 4'd0, 0);
        check("tog_1010", int'(q0), 10);
        cycle(0, 0, 1, 0, 1, 4'b1010, 4'd0, 0);
        check("tog_0000", int'(q0), 0);
        cycle(0, 0, 0, 0, 1, 4'b1111, 4'd0, 0);
        check("tog_hold", int'(q0), 0);

        // Out-of-range load.
        cycle(0, 1, 0, 1, 1, 4'b0000, 4'd13, 0);
        check("oor_tc", int'(tc0), 1);
        cycle(0, 0, 1, 1, 1, 4'b0000, 4'd0, 0);
        check("oor_up_q", int'(q0), 0);
        check("oor_up_wrap", int'(wrap0), 1);
        cycle(0, 1, 0, 1, 0, 4'b0000, 4'd13, 0);
        cycle(0, 0, 1, 1, 0, 4'b0000, 4'd0, 0);
        check("oor_dn_q", int'(q0), 12);

        // Priority.
        cycle(1, 1, 1, 1, 1, 4'b0000, 4'd5, 0);
        check("prio_rst", int'(q0), 0);
        cycle(0, 1, 1, 1, 1, 4'b0000, 4'd5, 0);
        check("prio_load", int'(q0), 5);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0));
        end

        // Two-stage cascade counting 0..99.
        cycle(1, 0, 0, 1, 1, 4'b0000, 4'd0, 0);
        check("cas_rst_hi", int'(q1), 0);
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 1, 1, 1, 4'b0000, 4'd0, 0);
            check("cas_lo", int'(q0), (i + 1) % 10);
            check("cas_hi", int'(q1), ((i + 1) / 10) % 10);
        end
        check("cas_hi_wrap", int'(wrap1), 1);
        check("cas_hi_tc", int'(tc1), 0);
        check("cas_hi_co", int'(co1), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/t_ff_counter.md
Name: t_ff_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop.
- WIDTH-bit register built from a bank of T flip-flops, with two modes:
  - bitwise toggle: per-bit T inputs;
  - modulo-MODULUS up/down counter: toggle vector derived internally.
- Adds synchronous load, count enable, terminal-count/carry for cascading, and a sticky wrap flag.
- Used as the generic counter/divider primitive in lab datapaths.

Parameters:
- WIDTH, 4, register width in bits (1..16).
- MODULUS, 16, count-mode modulus; legal range 2..2**WIDTH; count sequence 0..MODULUS-1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; no state change when low, except load.
- mode  input  1  0 = toggle mode, 1 = count mode.
- up_dn  input  1  count direction; 1 = up, 0 = down; ignored in toggle mode.
- t  input  WIDTH  per-bit toggle request; used in toggle mode only.
- load  input  1  synchronous parallel load.
- d  input  WIDTH  load value.
- clr_wrap  input  1  clears the sticky wrap flag.
- q  output  WIDTH  register state.
- tc  output  1  terminal count (combinational).
- co  output  1  carry out for cascading = tc & en & ~load.
- wrap  output  1  sticky flag: a count-mode wrap occurred.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: at a rising clk edge with rst=1, q <= 0 and wrap <= 0. rst overrides all other inputs. tc and co follow combinationally from the reset state.
- Priority per edge: rst > load > en > hold.
- Load (load=1, rst=0):
  - q <= d, independent of en and mode.
  - wrap <= 0.
  - d >= MODULUS is accepted unchanged; see the out-of-range rules below.
- Toggle mode (mode=0, en=1): q <= q ^ t. Latency 1 cycle; t=0 holds. wrap is unaffected.
- Count mode, up (mode=1, en=1, up_dn=1):
  - q <= 0 if q >= MODULUS-1, else q+1.
  - The case q >= MODULUS-1 is a wrap.
- Count mode, down (mode=1, en=1, up_dn=0):
  - q <= MODULUS-1 if q == 0; this is a wrap.
  - Otherwise q <= q-1. An out-of-range q simply decrements until it is back in range.
- Arithmetic: unsigned, WIDTH bits. With MODULUS = 2**WIDTH the up wrap equals natural overflow.
- Implementation: next state is computed as a value, then converted to a toggle vector tv = q ^ next. Every bit is a T flip-flop driven by tv. No adder output drives q directly.
- tc:
  - Asserted when mode=1 and ((up_dn=1 and q >= MODULUS-1) or (up_dn=0 and q == 0)).
  - Always 0 in toggle mode.
  - Combinational from current q/mode/up_dn; no dependency on en.
- co = tc & en & ~load. Chaining co into the next stage's en gives a synchronous cascade.
- wrap:
  - Set on any count-mode wrap edge.
  - Cleared by clr_wrap, load or rst.
  - Wrap and clr_wrap on the same edge: set wins (wrap=1).
- Mode or direction change mid-count takes effect on the next edge. There is no pipeline state to flush.
- Reset mid-count overrides a concurrent load, count or wrap in that cycle.
- Illegal parameters (MODULUS < 2 or MODULUS > 2**WIDTH) are rejected by an elaboration-time check.

Decomposition:
- Shared package:
  - MODE_TOGGLE=0, MODE_COUNT=1;
  - DIR_DOWN=0, DIR_UP=1;
  - WIDTH/MODULUS legality check function.
- Sub-module t_ff_cell: one T flip-flop with synchronous active-high reset. Ports: clk, rst, t, q. Instantiated WIDTH times in a generate loop.
- Next-state, tc and wrap logic live in the top module.

Test Plan:
- Reset: drive garbage on all inputs, rst=1 for 2 cycles -> q=0, wrap=0. Then rst=0 with mode=1, up_dn=1, en=1 -> q=0,1,2 on successive edges.
- Up wrap, WIDTH=4, MODULUS=10: load d=8, then count up 3 edges -> q=9 (tc=1, co=1), then 0 (wrap=1, tc=0), then 1. A clr_wrap pulse -> wrap=0.
- Down wrap, MODULUS=10: load d=1, count down -> q=0 (tc=1), then 9 (wrap=1), then 8. Assert clr_wrap on the wrap edge -> wrap stays 1.
- Toggle mode: q=4'b0000, t=4'b1010 for 2 edges -> 1010, then 0000. tc=0 throughout. en=0 with t=1111 -> q holds.
- Out-of-range load, MODULUS=10: load d=13 then count up -> q=0 and wrap=1. Load d=13 then count down -> q=12.
- Priority and cascade: on one edge assert load=1, en=1, d=5 with rst=1 -> q=0. Repeat with rst=0 -> q=5. Two instances with MODULUS=10, co of the first driving en of the second, count 0..99 -> upper stage increments exactly when the lower stage goes 9 -> 0.
